// File: rtl/core_pkg.sv
// Shared core definitions: opcode constants, NOP encoding, reset PC default,
// immediate extraction for B/J formats and the 2-bit saturating counter step.
package core_pkg;

  localparam logic [6:0]  OPC_BRANCH       = 7'b1100011;
  localparam logic [6:0]  OPC_JAL          = 7'b1101111;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [1:0]  BHT_INIT         = 2'b01;

  function automatic logic [31:0] imm_b(input logic [31:0] instr);
    return {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] imm_j(input logic [31:0] instr);
    return {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
  endfunction

  function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
    logic [1:0] res;
    if (taken) begin
      if (ctr != 2'b11) res = ctr + 2'b01;
      else              res = ctr;
    end else begin
      if (ctr != 2'b00) res = ctr - 2'b01;
      else              res = ctr;
    end
    return res;
  endfunction

endpackage

// File: rtl/branch_predictor.sv
// Bimodal branch history table: 2-bit saturating counters, combinational lookup
// of the stored (pre-update) value and a registered saturating update.
module branch_predictor
  import core_pkg::*;
#(
  parameter int ENTRIES = 16,
  localparam int IDX_W  = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] lookup_idx,
  output logic             pred_taken,
  input  logic             upd_valid,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken
);

  logic [1:0] bht_r [ENTRIES];
  logic [1:0] ctr_next_s;

  // Next value of the counter being trained
  always_comb begin
    ctr_next_s = sat_update(bht_r[upd_idx], upd_taken);
  end

  // Counter array with asynchronous reset to weakly not-taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        bht_r[i] <= BHT_INIT;
      end
    end else if (upd_valid) begin
      bht_r[upd_idx] <= ctr_next_s;
    end
  end

  assign pred_taken = bht_r[lookup_idx][1];

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, next-PC selection with JAL/branch
// prediction, IF/ID register. Define FETCH_BHT_EN for the dynamic BHT predictor.
module fetch_unit
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
  parameter int          BHT_ENTRIES = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic [31:0] pc_o,
  input  logic [31:0] instr_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        upd_valid_i,
  input  logic [31:0] upd_pc_i,
  input  logic        upd_taken_i,
  output logic        if_id_valid_o,
  output logic [31:0] if_id_instr_o,
  output logic [31:0] if_id_pc_o,
  output logic        if_id_pred_taken_o
);

  logic [31:0] pc_r;
  logic        if_valid_r;
  logic [31:0] if_instr_r;
  logic [31:0] if_pc_r;
  logic        if_pred_r;

  logic        is_branch_s;
  logic        is_jal_s;
  logic        branch_taken_s;
  logic        pred_taken_s;
  logic [31:0] target_s;
  logic [31:0] next_pc_s;

`ifdef FETCH_BHT_EN
  localparam int IDX_W = $clog2(BHT_ENTRIES);

  branch_predictor #(
    .ENTRIES(BHT_ENTRIES)
  ) u_bp (
    .clk       (clk_i),
    .rst_n     (rst_i),
    .lookup_idx(pc_r[IDX_W+1:2]),
    .pred_taken(branch_taken_s),
    .upd_valid (upd_valid_i),
    .upd_idx   (upd_pc_i[IDX_W+1:2]),
    .upd_taken (upd_taken_i)
  );

  logic unused_upd_s;
  assign unused_upd_s = ^{upd_pc_i[31:IDX_W+2], upd_pc_i[1:0]};
`else
  // Static BTFN: backward branches (negative B-immediate) predicted taken
  assign branch_taken_s = instr_i[31];

  logic unused_upd_s;
  assign unused_upd_s = ^{upd_valid_i, upd_taken_i, upd_pc_i, BHT_ENTRIES[0]};
`endif

  assign is_branch_s  = (instr_i[6:0] == OPC_BRANCH);
  assign is_jal_s     = (instr_i[6:0] == OPC_JAL);
  assign pred_taken_s = is_jal_s | (is_branch_s & branch_taken_s);

  // Predicted target for the word currently being fetched
  always_comb begin
    if (is_jal_s) target_s = pc_r + imm_j(instr_i);
    else          target_s = pc_r + imm_b(instr_i);
  end

  // Next-PC selection: redirect beats stall beats prediction
  always_comb begin
    if (redirect_i)        next_pc_s = redirect_pc_i;
    else if (stall_i)      next_pc_s = pc_r;
    else if (pred_taken_s) next_pc_s = target_s;
    else                   next_pc_s = pc_r + 32'd4;
  end

  // Program counter
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) pc_r <= RESET_PC;
    else        pc_r <= next_pc_s;
  end

  // IF/ID pipeline register; a redirect only drops valid, payload holds
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      if_valid_r <= 1'b0;
      if_instr_r <= NOP_INSTR;
      if_pc_r    <= 32'h0000_0000;
      if_pred_r  <= 1'b0;
    end else if (redirect_i) begin
      if_valid_r <= 1'b0;
    end else if (!stall_i) begin
      if_valid_r <= 1'b1;
      if_instr_r <= instr_i;
      if_pc_r    <= pc_r;
      if_pred_r  <= pred_taken_s;
    end
  end

  assign pc_o               = pc_r;
  assign if_id_valid_o      = if_valid_r;
  assign if_id_instr_o      = if_instr_r;
  assign if_id_pc_o         = if_pc_r;
  assign if_id_pred_taken_o = if_pred_r;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed cycle vectors push expected
// post-edge state; a monitor pops and compares after every rising edge.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] JAL = 32'h0100_006f;
  localparam logic [31:0] BNE = 32'hfe15_18e3;
  localparam logic [31:0] FWD = 32'h0010_8663;

  typedef struct {
    logic [31:0] pc;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] ipc;
    logic        pred;
    logic        full;
  } exp_t;

  logic        clk;
  logic        rst_i;
  logic [31:0] pc_o;
  logic [31:0] instr_i;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        upd_valid_i;
  logic [31:0] upd_pc_i;
  logic        upd_taken_i;
  logic        if_id_valid_o;
  logic [31:0] if_id_instr_o;
  logic [31:0] if_id_pc_o;
  logic        if_id_pred_taken_o;

  logic [31:0] mem [64];
  exp_t        sb [$];
  int          n_chk;
  int          n_fail;

  fetch_unit dut (
    .clk_i             (clk),
    .rst_i             (rst_i),
    .pc_o              (pc_o),
    .instr_i           (instr_i),
    .stall_i           (stall_i),
    .redirect_i        (redirect_i),
    .redirect_pc_i     (redirect_pc_i),
    .upd_valid_i       (upd_valid_i),
    .upd_pc_i          (upd_pc_i),
    .upd_taken_i       (upd_taken_i),
    .if_id_valid_o     (if_id_valid_o),
    .if_id_instr_o     (if_id_instr_o),
    .if_id_pc_o        (if_id_pc_o),
    .if_id_pred_taken_o(if_id_pred_taken_o)
  );

  assign instr_i = mem[pc_o[7:2]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drv(input logic s, input logic r, input logic [31:0] rp,
                     input logic uv, input logic [31:0] up, input logic ut);
    stall_i       = s;
    redirect_i    = r;
    redirect_pc_i = rp;
    upd_valid_i   = uv;
    upd_pc_i      = up;
    upd_taken_i   = ut;
  endtask

  task automatic expect_st(input logic [31:0] pc, input logic v, input logic [31:0] ins,
                           input logic [31:0] ipc, input logic pred, input logic full);
    exp_t e;
    e.pc = pc; e.valid = v; e.instr = ins; e.ipc = ipc; e.pred = pred; e.full = full;
    sb.push_back(e);
  endtask

  task automatic step(input logic s, input logic r, input logic [31:0] rp,
                      input logic uv, input logic [31:0] up, input logic ut,
                      input logic [31:0] pc, input logic v, input logic [31:0] ins,
                      input logic [31:0] ipc, input logic pred, input logic full);
    @(negedge clk);
    drv(s, r, rp, uv, up, ut);
    expect_st(pc, v, ins, ipc, pred, full);
  endtask

  // Monitor: compare DUT state after each edge against the oldest expectation
  always @(posedge clk) begin
    exp_t m;
    #1;
    if (rst_i && sb.size() > 0) begin
      m = sb.pop_front();
      check("pc", pc_o, m.pc);
      check("if_valid", {31'd0, if_id_valid_o}, {31'd0, m.valid});
      if (m.full) begin
        check("if_instr", if_id_instr_o, m.instr);
        check("if_pc", if_id_pc_o, m.ipc);
        check("if_pred", {31'd0, if_id_pred_taken_o}, {31'd0, m.pred});
      end
    end
  end

  initial begin
    n_chk = 0;
    n_fail = 0;
    rst_i = 1'b0;
    drv(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    for (int i = 0; i < 64; i++) mem[i] = NOP;
    mem[4] = JAL;
    mem[6] = BNE;

    repeat (3) @(negedge clk);
    check("rst_pc", pc_o, 32'h0);
    check("rst_valid", {31'd0, if_id_valid_o}, 32'd0);
    check("rst_instr", if_id_instr_o, NOP);
    check("rst_ipc", if_id_pc_o, 32'h0);
    check("rst_pred", {31'd0, if_id_pred_taken_o}, 32'd0);

    // release: first edge fetches RESET_PC
    rst_i = 1'b1;
    expect_st(32'h04, 1'b1, NOP, 32'h00, 1'b0, 1'b1);
    step(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'h08, 1'b1, NOP, 32'h04, 1'b0, 1'b1);
    // two-cycle stall at PC 8
    step(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'h08, 1'b1, NOP, 32'h04, 1'b0, 1'b1);
    step(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'h08, 1'b1, NOP, 32'h04, 1'b0, 1'b1);
    step(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'h0C, 1'b1, NOP, 32'h08, 1'b0, 1'b1);
    step(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'h10, 1'b1, NOP, 32'h0C, 1'b0, 1'b1);
    // JAL +16 at 0x10
    step(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'h20, 1'b1, JAL, 32'h10, 1'b1, 1'b1);
    // redirect wins over stall
    step(1'b1, 1'b1, 32'h40, 1'b0, 32'd0, 1'b0, 32'h40, 1'b0, NOP, 32'h0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'h44, 1'b1, NOP, 32'h40, 1'b0, 1'b1);
    step(1'b0, 1'b1, 32'h18, 1'b0, 32'd0, 1'b0, 32'h18, 1'b0, NOP, 32'h0, 1'b0, 1'b0);
`ifdef FETCH_BHT_EN
    // first encounter, same-cycle taken update: lookup sees counter 1
    step(1'b0, 1'b0, 32'd0, 1'b1, 32'h18, 1'b1, 32'h1C, 1'b1, BNE, 32'h18, 1'b0, 1'b1);
    step(1'b0, 1'b1, 32'h18, 1'b1, 32'h18, 1'b1, 32'h18, 1'b0, NOP, 32'h0, 1'b0, 1'b0);
    // counter 3 taken; same-cycle not-taken update leaves lookup at 3
    step(1'b0, 1'b0, 32'd0, 1'b1, 32'h18, 1'b0, 32'h08, 1'b1, BNE, 32'h18, 1'b1, 1'b1);
    step(1'b0, 1'b1, 32'h18, 1'b0, 32'd0, 1'b0, 32'h18, 1'b0, NOP, 32'h0, 1'b0, 1'b0);
    // counter 2 still taken, then trained down to 1
    step(1'b0, 1'b0, 32'd0, 1'b1, 32'h18, 1'b0, 32'h08, 1'b1, BNE, 32'h18, 1'b1, 1'b1);
    step(1'b0, 1'b1, 32'h18, 1'b0, 32'd0, 1'b0, 32'h18, 1'b0, NOP, 32'h0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'h1C, 1'b1, BNE, 32'h18, 1'b0, 1'b1);
`else
    // backward branch taken statically; update port has no effect
    step(1'b0, 1'b0, 32'd0, 1'b1, 32'h18, 1'b0, 32'h08, 1'b1, BNE, 32'h18, 1'b1, 1'b1);
`endif
    // forward branch at PC 0 is not taken
    @(negedge clk);
    mem[0] = FWD;
    drv(1'b0, 1'b1, 32'h0, 1'b0, 32'd0, 1'b0);
    expect_st(32'h00, 1'b0, NOP, 32'h0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'h04, 1'b1, FWD, 32'h00, 1'b0, 1'b1);

    // asynchronous reset mid-cycle
    @(posedge clk);
    #3;
    rst_i = 1'b0;
    #1;
    check("arst_pc", pc_o, 32'h0);
    check("arst_valid", {31'd0, if_id_valid_o}, 32'd0);
    check("arst_instr", if_id_instr_o, NOP);
    check("arst_ipc", if_id_pc_o, 32'h0);
    check("arst_pred", {31'd0, if_id_pred_taken_o}, 32'd0);
    @(negedge clk);
    rst_i = 1'b1;
    drv(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    expect_st(32'h04, 1'b1, FWD, 32'h00, 1'b0, 1'b1);

    repeat (3) @(negedge clk);
    check("sb_drain", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the five-stage core. The block owns the program counter and drives the fetch address into the combinational instruction cache. It captures the returned word into the IF/ID pipeline register and predicts branch and JAL targets. It also applies stall and redirect requests arriving from the hazard unit and the EX stage.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset.
- `BHT_ENTRIES`, default 16: number of 2-bit counters, power of two, minimum 2.
- `clk_i` input 1: clock; all state updates on the rising edge.
- `rst_i` input 1: reset, asynchronous and active-low.
- `pc_o` output 32: fetch address to the instruction cache; this is the current PC register.
- `instr_i` input 32: instruction word returned combinationally for `pc_o`.
- `stall_i` input 1: hold PC and IF/ID (load-use hazard).
- `redirect_i` input 1: mispredict or jump resolution from EX; flush and refetch.
- `redirect_pc_i` input 32: target for `redirect_i`.
- `upd_valid_i` input 1: BHT update strobe from EX for a resolved conditional branch.
- `upd_pc_i` input 32: PC of the resolved branch.
- `upd_taken_i` input 1: actual branch outcome.
- `if_id_valid_o` output 1: IF/ID holds a real instruction.
- `if_id_instr_o` output 32: instruction in IF/ID.
- `if_id_pc_o` output 32: PC of that instruction.
- `if_id_pred_taken_o` output 1: the fetch stage redirected after this instruction.

## Operation
- Decode is on `instr_i[6:0]`. BRANCH is 7'b1100011, JAL is 7'b1101111.
- Branch target is `pc_o` plus the sign-extended B-immediate. JAL target is `pc_o` plus the sign-extended J-immediate. All arithmetic is 32-bit modulo; wrap-around past 32'hFFFF_FFFC is permitted.
- Prediction rules:
  - JAL is always taken.
  - BRANCH is taken when the counter indexed by `pc_o[log2(BHT_ENTRIES)+1:2]` has MSB = 1.
  - Every other instruction is not taken.
- Next-PC priority: `redirect_i` → `redirect_pc_i`, then `stall_i` → hold, then predicted-taken → target, else `pc_o` + 4.
- IF/ID update:
  - On redirect, `if_id_valid_o` becomes 0; the instruction, PC and prediction fields are don't-care, held.
  - On stall without redirect, all IF/ID fields hold.
  - Otherwise IF/ID loads `instr_i`, `pc_o` and the prediction, with valid = 1.
- BHT update rules:
  - Counters are 2-bit saturating, indexed by `upd_pc_i`: increment on taken, decrement on not-taken.
  - Updates apply regardless of `stall_i` and `redirect_i`.
  - If lookup and update hit the same index in the same cycle, the lookup sees the pre-update value.
- Reset values:
  - PC = `RESET_PC`.
  - `if_id_valid_o` = 0, `if_id_instr_o` = 32'h0000_0013 (NOP), `if_id_pc_o` = 0, `if_id_pred_taken_o` = 0.
  - All counters = 2'b01 (weakly not-taken).
- Reset asserted mid-operation clears all of the above immediately and asynchronously.

## Timing
- `pc_o` is registered. `instr_i` is valid in the same cycle; the next-PC path is combinational from `instr_i`.
- Fetch latency: the instruction at `pc_o` appears in IF/ID one edge later.
- Redirect penalty: one bubble in IF/ID. The target is fetched in the cycle after `redirect_i`.
- Stall: PC and IF/ID are frozen for exactly the cycles in which `stall_i` = 1. If `stall_i` and `redirect_i` are high together, the redirect wins.
- First valid IF/ID entry (from `RESET_PC`) appears at the first edge after `rst_i` deasserts.

## Configuration
- `FETCH_BHT_EN` defined: dynamic BHT prediction as above; the `upd_*` ports are live.
- `FETCH_BHT_EN` undefined:
  - No BHT storage; the `upd_*` ports are ignored.
  - Static backward-taken/forward-not-taken: BRANCH is predicted taken iff the B-immediate sign bit (`instr_i[31]`) = 1.
  - JAL is still always taken.

## Structure
- Shared package `core_pkg`:
  - Constants: opcode constants, the NOP encoding, `RESET_PC` default.
  - Functions: immediate-extraction functions for the B and J formats.
- Sub-module `branch_predictor`: BHT array, lookup index/read, and saturating update. It is instantiated only under `FETCH_BHT_EN`.

## Test plan
- Reset: hold `rst_i`=0, then release.
  - While in reset, `pc_o`=0, `if_id_valid_o`=0 and `if_id_instr_o`=32'h00000013.
  - After release, `pc_o` steps 0, 4, 8.
- Stall: assert `stall_i` for 2 cycles at PC 8 → `pc_o` stays 8 and IF/ID stays {PC 4} for those cycles, then fetch resumes at 12.
- Redirect: assert `redirect_i` with `redirect_pc_i`=0x40 while `stall_i`=1 → next `pc_o`=0x40, next `if_id_valid_o`=0, then {PC 0x40, valid 1}.
- JAL: `instr_i`=32'h0100006f at PC 0x10 → next `pc_o`=0x20, `if_id_pred_taken_o`=1.
- BNE loop with `FETCH_BHT_EN`:
  - Stimulus: `fe1518e3` at 0x18, target 0x08.
  - First encounter: predicted not-taken, `pc_o`→0x1C.
  - After two taken updates for 0x18: predicted taken, `pc_o`→0x08.
  - After the update sequence taken, taken, not-taken: the prediction stays taken (counter 2).
- Same BNE without the macro: predicted taken on first encounter (`instr_i[31]`=1). A forward branch `00108663` at PC 0 is predicted not-taken, `pc_o`→4.
